// File: rtl/ifu_pkg.sv
// ---------------------------------------------------------------------------
// ifu_pkg
//   Shared types and constants for the instruction-fetch unit.
//   fetch_entry_t    : one {pc, inst} pair as carried from fetch to decode
//   INST_QUEUE_DEPTH : default fetch-to-decode queue depth
//   INST_QUEUE_SLACK : default number of in-flight fetches tolerated after full
//   RESET_PC         : architectural reset vector
// ---------------------------------------------------------------------------
package ifu_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam int          INST_QUEUE_DEPTH = 16;
    localparam int          INST_QUEUE_SLACK = 2;
    localparam logic [31:0] RESET_PC         = 32'hbfc0_0000;

endpackage

// File: rtl/inst_queue_if.sv
// ---------------------------------------------------------------------------
// inst_queue_if
//   Fetch/decode handshake bundle for the instruction queue.
//   master : fetch + decode side (drives flush, w_*, r_ena*; observes status/data)
//   slave  : the queue itself
//   Signals: flush, w_ena, w_pc, w_inst, full, r_ena1, r_ena2, r_valid1/2,
//            r_pc1/2, r_inst1/2, empty, count[AW:0]
// ---------------------------------------------------------------------------
interface inst_queue_if
    import ifu_pkg::*;
#(
    parameter int DEPTH = INST_QUEUE_DEPTH
) ();
    localparam int AW = $clog2(DEPTH);

    logic          flush;
    logic          w_ena;
    logic [31:0]   w_pc;
    logic [31:0]   w_inst;
    logic          full;
    logic          r_ena1;
    logic          r_ena2;
    logic          r_valid1;
    logic [31:0]   r_pc1;
    logic [31:0]   r_inst1;
    logic          r_valid2;
    logic [31:0]   r_pc2;
    logic [31:0]   r_inst2;
    logic          empty;
    logic [AW:0]   count;

    modport master (
        output flush, w_ena, w_pc, w_inst, r_ena1, r_ena2,
        input  full, r_valid1, r_pc1, r_inst1, r_valid2, r_pc2, r_inst2, empty, count
    );

    modport slave (
        input  flush, w_ena, w_pc, w_inst, r_ena1, r_ena2,
        output full, r_valid1, r_pc1, r_inst1, r_valid2, r_pc2, r_inst2, empty, count
    );

endinterface

// File: rtl/inst_queue_ram.sv
// ---------------------------------------------------------------------------
// inst_queue_ram
//   DEPTH x fetch_entry_t storage: one synchronous write port, two
//   asynchronous read ports (oldest and second-oldest slot).
//   clk            : clock
//   we/waddr/wdata : write port
//   raddr1/rdata1  : read port 1
//   raddr2/rdata2  : read port 2
// ---------------------------------------------------------------------------
module inst_queue_ram
    import ifu_pkg::*;
#(
    parameter  int DEPTH = INST_QUEUE_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         we,
    input  logic [AW-1:0] waddr,
    input  fetch_entry_t wdata,
    input  logic [AW-1:0] raddr1,
    input  logic [AW-1:0] raddr2,
    output fetch_entry_t rdata1,
    output fetch_entry_t rdata2
);

    fetch_entry_t mem [DEPTH];

    // NOTE: the array has no reset; occupancy lives in the control logic, so
    // stale contents are never observed and the array can map to plain RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata1 = mem[raddr1];
    assign rdata2 = mem[raddr2];

endmodule

// File: rtl/inst_queue.sv
// ---------------------------------------------------------------------------
// inst_queue
//   Fetch-to-decode instruction queue. Accepts one {pc, inst} per cycle and
//   presents the two oldest entries to dual-issue decode. full is raised at
//   DEPTH-SLACK entries so fetches already in flight still fit. flush empties
//   the queue and outranks any same-cycle push/pop.
//   clk, rst : clock, synchronous active-high reset
//   q        : inst_queue_if.slave bundle (see inst_queue_if)
//   Build option INST_QUEUE_BYPASS_EN: an empty queue forwards the incoming
//   fetch straight to slot 1 in the same cycle; if decode takes it, it is
//   never written.
// ---------------------------------------------------------------------------
module inst_queue
    import ifu_pkg::*;
#(
    parameter  int DEPTH = INST_QUEUE_DEPTH,
    parameter  int SLACK = INST_QUEUE_SLACK,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       rst,
    inst_queue_if.slave q
);

    localparam logic [AW:0] CNT_MAX  = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH - SLACK);

    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [AW-1:0] rptr_p1;
    logic [AW:0]   count_q;

    logic          have1;
    logic          have2;
    logic          byp_active;
    logic          byp_take;
    logic          push;
    logic          pop1;
    logic          pop2;
    logic [1:0]    pop_n;

    fetch_entry_t  wr_entry;
    fetch_entry_t  rd_entry1;
    fetch_entry_t  rd_entry2;

    assign have1   = (count_q != '0);
    assign have2   = (count_q > (AW+1)'(1));
    assign rptr_p1 = rptr_q + AW'(1);

`ifdef INST_QUEUE_BYPASS_EN
    assign byp_active = !have1 && q.w_ena && !q.flush;
`else
    assign byp_active = 1'b0;
`endif
    // A bypassed entry that decode takes this cycle must not also be stored.
    assign byp_take = byp_active && q.r_ena1;

    assign push  = q.w_ena && !q.flush && !rst && (count_q < CNT_MAX) && !byp_take;
    assign pop1  = q.r_ena1 && have1;
    assign pop2  = pop1 && q.r_ena2 && have2;
    assign pop_n = pop2 ? 2'd2 : {1'b0, pop1};

    assign wr_entry = '{pc: q.w_pc, inst: q.w_inst};

    inst_queue_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk    (clk),
        .we     (push),
        .waddr  (wptr_q),
        .wdata  (wr_entry),
        .raddr1 (rptr_q),
        .raddr2 (rptr_p1),
        .rdata1 (rd_entry1),
        .rdata2 (rd_entry2)
    );

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst || q.flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            rptr_q  <= rptr_q + AW'(pop_n);
            count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop_n);
        end
    end

    // Status comes only from the registered count, so full has no
    // combinational path from w_ena or r_ena*.
    assign q.full  = (count_q >= CNT_FULL);
    assign q.empty = !have1;
    assign q.count = count_q;

    // NOTE: every output gets a default first so no path can infer a latch.
    // Data is forced to zero while a slot is empty, which also gives the
    // cleared outputs after reset without resetting the array.
    always_comb begin
        q.r_valid1 = have1;
        q.r_pc1    = '0;
        q.r_inst1  = '0;
        q.r_valid2 = have2;
        q.r_pc2    = '0;
        q.r_inst2  = '0;
        if (byp_active) begin
            q.r_valid1 = 1'b1;
            q.r_pc1    = q.w_pc;
            q.r_inst1  = q.w_inst;
        end else if (have1) begin
            q.r_pc1    = rd_entry1.pc;
            q.r_inst1  = rd_entry1.inst;
        end
        if (have2) begin
            q.r_pc2    = rd_entry2.pc;
            q.r_inst2  = rd_entry2.inst;
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// ---------------------------------------------------------------------------
// tb_inst_queue
//   Self-checking bench for inst_queue. A queue-based reference model tracks
//   the expected contents; directed scenarios cover fill/full/drop, dual pop
//   with wrap, flush, bypass behaviour and reset, followed by randomized
//   traffic. Honours INST_QUEUE_BYPASS_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_inst_queue;
    import ifu_pkg::*;

    localparam int DEPTH = 16;
    localparam int SLACK = 2;
`ifdef INST_QUEUE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inst_queue_if #(.DEPTH(DEPTH)) q_if ();

    inst_queue #(
        .DEPTH (DEPTH),
        .SLACK (SLACK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .q   (q_if)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] model_q[$];
    logic [31:0] next_pc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Apply one cycle's worth of inputs; new pcs advance by 4 per push request.
    task automatic drive(input bit we, input bit r1, input bit r2, input bit fl, input bit rs);
        rst         = rs;
        q_if.flush  = fl;
        q_if.w_ena  = we;
        q_if.w_pc   = next_pc;
        q_if.w_inst = $urandom;
        q_if.r_ena1 = r1;
        q_if.r_ena2 = r2;
        if (we) next_pc = next_pc + 32'd4;
    endtask

    task automatic compare_outputs(input string tag);
        int sz;
        bit byp;
        sz  = model_q.size();
        byp = BYPASS && (sz == 0) && q_if.w_ena && !q_if.flush;
        check({tag, ".count"},  64'(q_if.count),    64'(sz));
        check({tag, ".empty"},  64'(q_if.empty),    64'(sz == 0));
        check({tag, ".full"},   64'(q_if.full),     64'(sz >= DEPTH - SLACK));
        check({tag, ".valid1"}, 64'(q_if.r_valid1), 64'((sz >= 1) || byp));
        check({tag, ".valid2"}, 64'(q_if.r_valid2), 64'(sz >= 2));
        if (byp) begin
            check({tag, ".byp1"}, {q_if.r_pc1, q_if.r_inst1}, {q_if.w_pc, q_if.w_inst});
        end else if (sz >= 1) begin
            check({tag, ".slot1"}, {q_if.r_pc1, q_if.r_inst1}, model_q[0]);
        end
        if (sz >= 2) begin
            check({tag, ".slot2"}, {q_if.r_pc2, q_if.r_inst2}, model_q[1]);
        end
    endtask

    // Reference behaviour: flush/reset empties; otherwise pop up to two from
    // the front (old data), then append the push if there was room.
    task automatic model_update();
        int sz;
        int n;
        bit take;
        sz = model_q.size();
        n  = 0;
        if (rst || q_if.flush) begin
            model_q.delete();
            return;
        end
        if (q_if.r_ena1 && sz >= 1) n = 1;
        if (n == 1 && q_if.r_ena2 && sz >= 2) n = 2;
        take = BYPASS && (sz == 0) && q_if.w_ena && q_if.r_ena1;
        for (int i = 0; i < n; i++) void'(model_q.pop_front());
        if (q_if.w_ena && sz < DEPTH && !take) model_q.push_back({q_if.w_pc, q_if.w_inst});
    endtask

    // Inputs are applied at posedge+1; outputs are checked at posedge+3.
    task automatic cycle(input string tag);
        #2;
        compare_outputs(tag);
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, ".count"},  64'(q_if.count),    64'd0);
        check({tag, ".empty"},  64'(q_if.empty),    64'd1);
        check({tag, ".full"},   64'(q_if.full),     64'd0);
        check({tag, ".valid1"}, 64'(q_if.r_valid1), 64'd0);
        check({tag, ".valid2"}, 64'(q_if.r_valid2), 64'd0);
        check({tag, ".data"},   {q_if.r_pc1, q_if.r_inst1}, 64'd0);
        check({tag, ".data2"},  {q_if.r_pc2, q_if.r_inst2}, 64'd0);
    endtask

    initial begin
        logic [31:0] pc_mark;
        next_pc = RESET_PC;

        // Reset state
        drive(0, 0, 0, 0, 1);
        repeat (2) @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0);
        #2;
        check_cleared("reset");
        cycle("reset_idle");

        // 1: four pushes, no reads
        next_pc = RESET_PC;
        repeat (4) begin drive(1, 0, 0, 0, 0); cycle("t1_push"); end
        drive(0, 0, 0, 0, 0);
        #2;
        check("t1.count", 64'(q_if.count), 64'd4);
        check("t1.pc1",   64'(q_if.r_pc1), 64'h0000_0000_bfc0_0000);
        check("t1.pc2",   64'(q_if.r_pc2), 64'h0000_0000_bfc0_0004);
        check("t1.full",  64'(q_if.full),  64'd0);
        cycle("t1_idle");

        // 2: fill to full threshold, then to DEPTH, then overflow drop
        drive(0, 0, 0, 1, 0); cycle("t2_flush");
        for (int i = 1; i <= 17; i++) begin
            drive(1, 0, 0, 0, 0);
            cycle("t2_push");
            if (i == 13) check("t2.full_at13", 64'(q_if.full), 64'd0);
            if (i == 14) check("t2.full_at14", 64'(q_if.full), 64'd1);
            if (i == 16) check("t2.count16",   64'(q_if.count), 64'd16);
            if (i == 17) check("t2.count_drop", 64'(q_if.count), 64'd16);
        end

        // 3: dual pop with push at count 3, then wrapping traffic
        drive(0, 0, 0, 1, 0); cycle("t3_flush");
        pc_mark = next_pc;
        repeat (3) begin drive(1, 0, 0, 0, 0); cycle("t3_push"); end
        drive(1, 1, 1, 0, 0); cycle("t3_pop2");
        check("t3.count", 64'(q_if.count), 64'd2);
        check("t3.pc1",   64'(q_if.r_pc1), 64'(pc_mark + 32'd8));
        for (int i = 0; i < 40; i++) begin
            drive(1, 1'($urandom), 1'($urandom), 0, 0);
            cycle("t3_wrap");
        end

        // 4: flush beats push and pop
        drive(0, 0, 0, 1, 0); cycle("t4_flush0");
        repeat (5) begin drive(1, 0, 0, 0, 0); cycle("t4_push"); end
        check("t4.count5", 64'(q_if.count), 64'd5);
        drive(1, 1, 0, 1, 0); cycle("t4_flush");
        drive(0, 0, 0, 0, 0);
        #2;
        check("t4.count",  64'(q_if.count),    64'd0);
        check("t4.empty",  64'(q_if.empty),    64'd1);
        check("t4.valid1", 64'(q_if.r_valid1), 64'd0);
        cycle("t4_idle");

        // 5: push and read on an empty queue
        drive(1, 1, 0, 0, 0);
        pc_mark = q_if.w_pc;
        #2;
`ifdef INST_QUEUE_BYPASS_EN
        check("t5.byp_valid1", 64'(q_if.r_valid1), 64'd1);
        check("t5.byp_pc1",    64'(q_if.r_pc1),    64'(pc_mark));
`else
        check("t5.valid1",     64'(q_if.r_valid1), 64'd0);
`endif
        cycle("t5_push_pop");
        drive(0, 0, 0, 0, 0);
        #2;
`ifdef INST_QUEUE_BYPASS_EN
        check("t5.byp_count", 64'(q_if.count), 64'd0);
`else
        check("t5.count",     64'(q_if.count), 64'd1);
        check("t5.pc1",       64'(q_if.r_pc1), 64'(pc_mark));
`endif
        cycle("t5_idle");

        // 6: r_ena2 alone does not pop; reset mid-operation clears everything
        drive(0, 0, 0, 1, 0); cycle("t6_flush");
        repeat (2) begin drive(1, 0, 0, 0, 0); cycle("t6_push"); end
        drive(0, 0, 1, 0, 0); cycle("t6_ena2_only");
        check("t6.count2", 64'(q_if.count), 64'd2);
        repeat (5) begin drive(1, 0, 0, 0, 0); cycle("t6_fill"); end
        check("t6.count7", 64'(q_if.count), 64'd7);
        drive(0, 0, 0, 0, 1); cycle("t6_rst");
        drive(0, 0, 0, 0, 0);
        #2;
        check_cleared("t6_after_rst");
        cycle("t6_idle");

        // Randomized traffic: alternating fill-biased and drain-biased phases
        for (int blk = 0; blk < 8; blk++) begin
            for (int i = 0; i < 50; i++) begin
                bit we;
                bit r1;
                we = (blk % 2 == 0) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 3);
                r1 = (blk % 2 == 0) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 8);
                drive(we, r1, 1'($urandom), ($urandom_range(0, 99) < 2),
                      ($urandom_range(0, 199) == 0));
                cycle("rand");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
